// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART receive definitions: FSM state encoding,
//               parity-mode constants and a constant-evaluable clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int STATE_W = 3;

    // Receiver FSM states
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_BRKWAIT = 3'd5
    } rx_state_e;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Ceiling log2, usable in parameter/localparam expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Multi-flop synchroniser for an asynchronous, idle-high line.
//               All stages reset to 1 so leaving reset never shows a falling
//               edge to the logic downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int p_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [p_STAGES-1:0] sync_q;

    // Shift the raw line through the synchroniser chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[p_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[p_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver. Synchronised line, 3-sample
//               majority vote around mid-bit, configurable word length,
//               parity and stop bits, parity/framing/break reporting.
//               Completes a frame at mid-stop-bit so a start edge directly
//               after the stop bit is still caught.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int p_CLK_DIV     = 16,
    parameter int p_WORD_LEN    = 8,
    parameter int p_PARITY      = 0,
    parameter int p_STOP_BITS   = 1,
    parameter int p_SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_rx,
    output logic [p_WORD_LEN-1:0] o_data,
    output logic                  o_dv,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_busy
);

    localparam int CNT_W = clog2(p_CLK_DIV);
    localparam int BIT_W = clog2(p_WORD_LEN + 1);
    localparam int MID   = (p_CLK_DIV - 1) / 2;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] c_CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] c_CNT_VOTE = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(p_CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(p_WORD_LEN - 1);
    localparam logic             c_PAR_EN   = (p_PARITY != PAR_NONE);
    localparam logic             c_PAR_ODD  = (p_PARITY == PAR_ODD);
    localparam logic             c_TWO_STOP = (p_STOP_BITS == 2);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [p_WORD_LEN-1:0] shreg_q, shreg_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;
    logic                  stop0_low_q, stop0_low_d;
    logic [p_WORD_LEN-1:0] data_q, data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  fe_q, fe_d;
    logic                  brk_q, brk_d;

    logic                  w_rxs;
    logic                  w_vote;
    logic                  w_at_vote;
    logic                  w_at_last;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_done;
    logic                  w_frm_err_fin;
    logic                  w_stop0_low_fin;
    logic                  w_brk;

    uart_rx_sync #(
        .p_STAGES (p_SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (w_rxs)
    );

    // Bit timing, majority vote and end-of-frame decode
    always_comb begin
        w_at_vote       = (clk_cnt_q == c_CNT_VOTE);
        w_at_last       = (clk_cnt_q == c_CNT_LAST);
        w_cnt_next      = w_at_last ? '0 : clk_cnt_q + CNT_W'(1);
        w_vote          = (samp_q[0] & samp_q[1]) | (samp_q[0] & w_rxs) | (samp_q[1] & w_rxs);
        w_frm_err_fin   = frm_err_q | ~w_vote;
        w_stop0_low_fin = (stop_cnt_q == 1'b0) ? ~w_vote : stop0_low_q;
        w_brk           = (shreg_q == '0) && !par_bit_q && w_stop0_low_fin;
        w_done          = i_en && (state_q == ST_STOP) && w_at_vote && (stop_cnt_q == c_TWO_STOP);
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; disabling the receiver always forces IDLE
    always_comb begin
        state_d = state_q;
        if (!i_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_rxs) state_d = ST_START;
                end
                ST_START: begin
                    if (w_at_vote && w_vote) state_d = ST_IDLE;
                    else if (w_at_last)      state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (w_at_last && (bit_cnt_q == c_BIT_LAST)) begin
                        state_d = c_PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (w_at_last) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (w_done) state_d = w_brk ? ST_BRKWAIT : ST_IDLE;
                end
                ST_BRKWAIT: begin
                    if (w_rxs) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: busy flag plus next values of counters and datapath
    always_comb begin
        o_busy      = (state_q != ST_IDLE);
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        stop0_low_d = stop0_low_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        fe_d        = 1'b0;
        brk_d       = 1'b0;

        // The first two vote samples are captured purely on count value
        if (clk_cnt_q == c_CNT_S0) samp_d[0] = w_rxs;
        if (clk_cnt_q == c_CNT_S1) samp_d[1] = w_rxs;

        if (!i_en) begin
            clk_cnt_d  = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        // The falling edge itself counts as sample 0 of the start bit
                        clk_cnt_d   = c_CNT_ONE;
                        bit_cnt_d   = '0;
                        stop_cnt_d  = 1'b0;
                        par_bit_d   = 1'b0;
                        par_err_d   = 1'b0;
                        frm_err_d   = 1'b0;
                        stop0_low_d = 1'b0;
                    end
                end
                ST_START: begin
                    clk_cnt_d = (w_at_vote && w_vote) ? '0 : w_cnt_next;
                end
                ST_DATA: begin
                    clk_cnt_d = w_cnt_next;
                    // LSB arrives first, so shifting right leaves it at bit 0
                    if (w_at_vote) shreg_d = {w_vote, shreg_q[p_WORD_LEN-1:1]};
                    if (w_at_last) bit_cnt_d = (bit_cnt_q == c_BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
                end
                ST_PARITY: begin
                    clk_cnt_d = w_cnt_next;
                    if (w_at_vote) begin
                        par_bit_d = w_vote;
                        par_err_d = ((^shreg_q) ^ w_vote) != c_PAR_ODD;
                    end
                end
                ST_STOP: begin
                    if (w_done) begin
                        clk_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        dv_d       = 1'b1;
                        data_d     = w_brk ? '0 : shreg_q;
                        pe_d       = par_err_q;
                        fe_d       = w_frm_err_fin | w_brk;
                        brk_d      = w_brk;
                    end else begin
                        clk_cnt_d = w_cnt_next;
                        if (w_at_vote) begin
                            frm_err_d   = w_frm_err_fin;
                            stop0_low_d = w_stop0_low_fin;
                        end
                        if (w_at_last) stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Counters, shift register and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            samp_q      <= '1;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            stop0_low_q <= 1'b0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            fe_q        <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            samp_q      <= samp_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            stop0_low_q <= stop0_low_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            fe_q        <= fe_d;
            brk_q       <= brk_d;
        end
    end

    assign o_data       = data_q;
    assign o_dv         = dv_q;
    assign o_parity_err = pe_q;
    assign o_frame_err  = fe_q;
    assign o_break      = brk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Self-checking bench for uart_rx_os in 8N1, 8E1 and 8N2
//               configurations. Frames are built bit by bit, expected words,
//               flags and completion cycles come from a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int DIV  = 16;
    localparam int MID  = (DIV - 1) / 2;
    localparam int SYNC = 2;

    localparam int CTL_NONE   = 0;
    localparam int CTL_GLITCH = 1;
    localparam int CTL_EN     = 2;
    localparam int CTL_RST    = 3;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
        int         cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n, en;
    logic rx_n1, rx_e1, rx_n2;
    logic [7:0] d_n1, d_e1, d_n2;
    logic dv_n1, dv_e1, dv_n2, pe_n1, pe_e1, pe_n2;
    logic fe_n1, fe_e1, fe_n2, brk_n1, brk_e1, brk_n2;
    logic busy_n1, busy_e1, busy_n2;
    logic pdv_n1 = 1'b0, pdv_e1 = 1'b0, pdv_n2 = 1'b0;

    int cyc = 0;
    int stray = 0;
    int n_checks = 0;
    int n_errors = 0;

    rec_t rx_q0[$], rx_q1[$], rx_q2[$];
    rec_t ex_q0[$], ex_q1[$], ex_q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_PARITY(0), .p_STOP_BITS(1), .p_SYNC_STAGES(SYNC)) dut_n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rx_n1), .o_data(d_n1), .o_dv(dv_n1),
        .o_parity_err(pe_n1), .o_frame_err(fe_n1), .o_break(brk_n1), .o_busy(busy_n1));
    uart_rx_os #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_PARITY(2), .p_STOP_BITS(1), .p_SYNC_STAGES(SYNC)) dut_e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rx_e1), .o_data(d_e1), .o_dv(dv_e1),
        .o_parity_err(pe_e1), .o_frame_err(fe_e1), .o_break(brk_e1), .o_busy(busy_e1));
    uart_rx_os #(.p_CLK_DIV(DIV), .p_WORD_LEN(8), .p_PARITY(0), .p_STOP_BITS(2), .p_SYNC_STAGES(SYNC)) dut_n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rx(rx_n2), .o_data(d_n2), .o_dv(dv_n2),
        .o_parity_err(pe_n2), .o_frame_err(fe_n2), .o_break(brk_n2), .o_busy(busy_n2));

    function automatic rec_t mk_rec(input logic [7:0] d, input logic pe, input logic fe, input logic brk, input int c);
        rec_t r;
        r.data = d; r.pe = pe; r.fe = fe; r.brk = brk; r.cyc = c;
        return r;
    endfunction

    // Capture every completed frame; count over-long pulses and stray flags
    always @(negedge clk) begin
        if (dv_n1) rx_q0.push_back(mk_rec(d_n1, pe_n1, fe_n1, brk_n1, cyc));
        if (dv_e1) rx_q1.push_back(mk_rec(d_e1, pe_e1, fe_e1, brk_e1, cyc));
        if (dv_n2) rx_q2.push_back(mk_rec(d_n2, pe_n2, fe_n2, brk_n2, cyc));
        if ((dv_n1 && pdv_n1) || (!dv_n1 && (pe_n1 || fe_n1 || brk_n1)) ||
            (dv_e1 && pdv_e1) || (!dv_e1 && (pe_e1 || fe_e1 || brk_e1)) ||
            (dv_n2 && pdv_n2) || (!dv_n2 && (pe_n2 || fe_n2 || brk_n2)))
            stray <= stray + 1;
        pdv_n1 <= dv_n1;
        pdv_e1 <= dv_e1;
        pdv_n2 <= dv_n2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pmode_of(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction

    function automatic int nstop_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: expected word, flags and dv cycle
    function automatic rec_t model(input logic [7:0] d, input int pmode, input logic pbit,
                                   input logic st0, input logic st1, input int nstop, input int start);
        rec_t r;
        int   n;
        logic brk;
        n       = 1 + 8 + ((pmode != 0) ? 1 : 0) + nstop;
        brk     = (d == 8'h00) && ((pmode == 0) || !pbit) && !st0;
        r.data  = brk ? 8'h00 : d;
        r.pe    = (pmode == 0) ? 1'b0 : (((^d) ^ pbit) != (pmode == 1));
        r.fe    = brk || !st0 || ((nstop == 2) && !st1);
        r.brk   = brk;
        r.cyc   = start + SYNC + (n - 1) * DIV + MID + 2;
        return r;
    endfunction

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0: rx_n1 = v;
            1: rx_e1 = v;
            default: rx_n2 = v;
        endcase
    endtask

    function automatic int rx_size(input int sel);
        case (sel)
            0: return rx_q0.size();
            1: return rx_q1.size();
            default: return rx_q2.size();
        endcase
    endfunction

    function automatic rec_t rx_pop(input int sel);
        case (sel)
            0: return rx_q0.pop_front();
            1: return rx_q1.pop_front();
            default: return rx_q2.pop_front();
        endcase
    endfunction

    function automatic int ex_size(input int sel);
        case (sel)
            0: return ex_q0.size();
            1: return ex_q1.size();
            default: return ex_q2.size();
        endcase
    endfunction

    function automatic rec_t ex_pop(input int sel);
        case (sel)
            0: return ex_q0.pop_front();
            1: return ex_q1.pop_front();
            default: return ex_q2.pop_front();
        endcase
    endfunction

    task automatic ex_push(input int sel, input rec_t r);
        case (sel)
            0: ex_q0.push_back(r);
            1: ex_q1.push_back(r);
            default: ex_q2.push_back(r);
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drive one frame bit by bit, with an optional glitch, enable drop or reset pulse
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit, input logic st0,
                              input logic st1, input int ctl, input int ctl_at, output int start);
        logic [15:0] bits;
        int          nb;
        logic        v;
        bits = '1;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i]; nb++;
        end
        if (pmode_of(sel) != 0) begin
            bits[nb] = pbit; nb++;
        end
        bits[nb] = st0; nb++;
        if (nstop_of(sel) == 2) begin
            bits[nb] = st1; nb++;
        end
        start = cyc;
        for (int o = 0; o < nb * DIV; o++) begin
            v = bits[o / DIV];
            if (ctl == CTL_GLITCH && o == ctl_at) v = ~v;
            if (ctl == CTL_EN && o == ctl_at) en = 1'b0;
            if (ctl == CTL_RST && o == ctl_at) rst_n = 1'b0;
            if (ctl == CTL_RST && o == ctl_at + 2) begin
                check_eq("rst_mid_outs", 32'({d_n1, dv_n1, pe_n1, fe_n1, brk_n1, busy_n1}), 32'd0);
                rst_n = 1'b1;
            end
            set_line(sel, v);
            @(negedge clk);
        end
        set_line(sel, 1'b1);
    endtask

    task automatic run_frame(input int sel, input logic [7:0] d, input logic pbit, input logic st0,
                             input logic st1, input int ctl, input int ctl_at, input bit expect_dv);
        int start;
        send_frame(sel, d, pbit, st0, st1, ctl, ctl_at, start);
        if (expect_dv) ex_push(sel, model(d, pmode_of(sel), pbit, st0, st1, nstop_of(sel), start));
    endtask

    // Compare received frames against expectations, in order
    task automatic drain(input int sel, input string tag);
        rec_t e, r;
        while (ex_size(sel) > 0) begin
            e = ex_pop(sel);
            check_eq({tag, "_dv"}, 32'(rx_size(sel) > 0), 32'd1);
            if (rx_size(sel) > 0) begin
                r = rx_pop(sel);
                check_eq({tag, "_data"}, 32'(r.data), 32'(e.data));
                check_eq({tag, "_perr"}, 32'(r.pe), 32'(e.pe));
                check_eq({tag, "_ferr"}, 32'(r.fe), 32'(e.fe));
                check_eq({tag, "_brk"}, 32'(r.brk), 32'(e.brk));
                check_eq({tag, "_cycle"}, 32'(r.cyc), 32'(e.cyc));
            end
        end
        check_eq({tag, "_extra_dv"}, 32'(rx_size(sel)), 32'd0);
        while (rx_size(sel) > 0) void'(rx_pop(sel));
    endtask

    initial begin
        int   start;
        int   gap;
        logic [7:0] d;
        logic pb;

        rst_n = 1'b0; en = 1'b1;
        rx_n1 = 1'b1; rx_e1 = 1'b1; rx_n2 = 1'b1;
        wait_cycles(3);
        check_eq("reset_outs_n1", 32'({d_n1, dv_n1, pe_n1, fe_n1, brk_n1, busy_n1}), 32'd0);
        check_eq("reset_outs_e1", 32'({d_e1, dv_e1, pe_e1, fe_e1, brk_e1, busy_e1}), 32'd0);
        rst_n = 1'b1;
        wait_cycles(5);
        check_eq("reset_exit_busy", 32'({busy_n1, busy_e1, busy_n2}), 32'd0);

        // 8N1 back to back, zero idle gap
        run_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        run_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        wait_cycles(40);
        drain(0, "b2b");

        // 8N1 random words, random gaps, random single-sample glitches
        for (int k = 0; k < 12; k++) begin
            gap = $urandom_range(0, 24);
            if (gap > 0) wait_cycles(gap);
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                run_frame(0, d, 1'b0, 1'b1, 1'b1, CTL_GLITCH,
                          $urandom_range(0, 9) * DIV + MID - 1 + $urandom_range(0, 2), 1'b1);
            else
                run_frame(0, d, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        end
        wait_cycles(40);
        drain(0, "rand8n1");

        // 8E1: fixed 0x07 with both parity values, then random words and parity bits
        run_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        run_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            d  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            run_frame(1, d, pb, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        end
        wait_cycles(40);
        drain(1, "par8e1");

        // 8N2: second stop bit low, then clean frames
        run_frame(2, 8'h55, 1'b0, 1'b1, 1'b0, CTL_NONE, 0, 1'b1);
        wait_cycles(40);
        run_frame(2, 8'hC3, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            run_frame(2, d, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        end
        wait_cycles(40);
        drain(2, "frm8n2");

        // Short low pulse is a false start
        rx_n1 = 1'b0;
        wait_cycles(5);
        check_eq("noise_busy_high", 32'(busy_n1), 32'd1);
        rx_n1 = 1'b1;
        wait_cycles(40);
        check_eq("noise_busy_low", 32'(busy_n1), 32'd0);
        drain(0, "noise");

        // Glitch at mid-bit of data bit 3
        run_frame(0, 8'hF0, 1'b0, 1'b1, 1'b1, CTL_GLITCH, 4 * DIV + MID, 1'b1);
        wait_cycles(40);
        drain(0, "glitch");

        // Enable dropped during data bit 4: no output, word held
        run_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, CTL_EN, 5 * DIV + 4, 1'b0);
        wait_cycles(2);
        check_eq("abort_busy", 32'(busy_n1), 32'd0);
        check_eq("abort_data_held", 32'(d_n1), 32'h0000_00F0);
        en = 1'b1;
        wait_cycles(40);
        drain(0, "abort");
        run_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        wait_cycles(40);
        drain(0, "after_abort");

        // Break: 12 bit times low, then high
        rx_n1 = 1'b0;
        start = cyc;
        wait_cycles(12 * DIV);
        check_eq("brk_single_dv", 32'(rx_size(0)), 32'd1);
        check_eq("brk_wait_busy", 32'(busy_n1), 32'd1);
        rx_n1 = 1'b1;
        wait_cycles(40);
        check_eq("brk_release_busy", 32'(busy_n1), 32'd0);
        ex_push(0, model(8'h00, 0, 1'b0, 1'b0, 1'b1, 1, start));
        drain(0, "break");

        // Reset pulse mid-frame
        run_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, CTL_RST, 3 * DIV + 5, 1'b0);
        wait_cycles(40);
        check_eq("rst_after_busy", 32'(busy_n1), 32'd0);
        check_eq("rst_after_data", 32'(d_n1), 32'd0);
        drain(0, "rst");
        run_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, CTL_NONE, 0, 1'b1);
        wait_cycles(40);
        drain(0, "after_rst");

        check_eq("stray_pulse_or_flag", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
